// File: rtl/fir_4tap_inv.sv
`default_nettype none
// ============================================================================
// Module   : fir_4tap_inv
// Purpose  : Inverse filter for an all-ones moving-sum FIR. It rebuilds the
//            original samples from the filtered stream using
//            x[n] = y[n] - y[n-1] + x[n-TAPS].
//            The datapath is recursive, with an input-valid qualifier, a
//            priming state machine and sticky overflow detection.
// Options  : FIR_INV_SAT_EN - when defined, an out-of-range result is
//            clamped to the DW_OUT range. When undefined, the result wraps
//            in two's complement. Err is set on overflow in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module fir_4tap_inv #(
    parameter int DW_IN  = 32,
    parameter int DW_OUT = 16,
    parameter int TAPS   = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Clr,
    input  logic signed [DW_IN-1:0]  Yin,
    input  logic                     Yin_valid,
    output logic signed [DW_OUT-1:0] Xout,
    output logic                     Xout_valid,
    output logic                     Primed,
    output logic                     Err
);

    localparam int c_CW = (TAPS > 2) ? $clog2(TAPS) : 1;
    localparam int c_SW = DW_IN + 2;

    // The representable output range, widened to the width of the sum.
    localparam logic signed [c_SW-1:0] c_MAX =
        {{(c_SW-DW_OUT+1){1'b0}}, {(DW_OUT-1){1'b1}}};
    localparam logic signed [c_SW-1:0] c_MIN =
        {{(c_SW-DW_OUT+1){1'b1}}, {(DW_OUT-1){1'b0}}};
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TAPS - 1);

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_CW-1:0]          r_cnt;
    logic [c_CW-1:0]          w_cnt_nxt;
    logic signed [DW_IN-1:0]  r_y_prev;
    logic signed [DW_OUT-1:0] r_x_hist [TAPS];

    logic signed [DW_IN:0]    w_d;
    logic signed [c_SW-1:0]   w_s;
    logic                     w_hi;
    logic                     w_lo;
    logic signed [DW_OUT-1:0] w_lim;
    logic                     w_accept;

    assign w_accept = Yin_valid & ~Clr;

    // Difference and recursive sum. Each operand is sign-extended by hand,
    // so the sum is full precision and cannot overflow internally.
    assign w_d = $signed({Yin[DW_IN-1], Yin}) - $signed({r_y_prev[DW_IN-1], r_y_prev});
    assign w_s = $signed({w_d[DW_IN], w_d})
               + $signed({{(c_SW-DW_OUT){r_x_hist[TAPS-1][DW_OUT-1]}}, r_x_hist[TAPS-1]});

    assign w_hi = (w_s > c_MAX);
    assign w_lo = (w_s < c_MIN);

    // Limit the result to DW_OUT bits, by clamping or by wrapping.
    always_comb begin
        w_lim = w_s[DW_OUT-1:0];
`ifdef FIR_INV_SAT_EN
        if (w_hi) begin
            w_lim = {1'b0, {(DW_OUT-1){1'b1}}};
        end else if (w_lo) begin
            w_lim = {1'b1, {(DW_OUT-1){1'b0}}};
        end
`endif
    end

    // Priming FSM, next state. The counter stops once TAPS samples are in.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (Clr) begin
            w_state_nxt = PRIME;
            w_cnt_nxt   = '0;
        end else if (Yin_valid) begin
            case (r_state)
                PRIME: begin
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = PRIME;
            endcase
        end
    end

    // Priming FSM state register. Primed follows the next state, so it rises
    // on the same edge that produces the TAPS-th output.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= PRIME;
            r_cnt   <= '0;
            Primed  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            Primed  <= (w_state_nxt == RUN);
        end
    end

    // Datapath registers. History holds the limited output. Cycles with
    // Yin_valid low leave every register unchanged.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Xout       <= '0;
            Xout_valid <= 1'b0;
            Err        <= 1'b0;
            r_y_prev   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_x_hist[i] <= '0;
            end
        end else if (Clr) begin
            Xout       <= '0;
            Xout_valid <= 1'b0;
            Err        <= 1'b0;
            r_y_prev   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_x_hist[i] <= '0;
            end
        end else begin
            Xout_valid <= w_accept;
            if (w_accept) begin
                Xout        <= w_lim;
                r_y_prev    <= Yin;
                r_x_hist[0] <= w_lim;
                for (int i = 1; i < TAPS; i++) begin
                    r_x_hist[i] <= r_x_hist[i-1];
                end
                if (w_hi | w_lo) begin
                    Err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_4tap_inv.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_4tap_inv
// Purpose  : Directed self-checking bench for fir_4tap_inv. Expected values
//            are worked out by hand. The bench covers both builds of
//            FIR_INV_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_4tap_inv;

    logic               Clk;
    logic               Rst;
    logic               Clr;
    logic signed [31:0] Yin;
    logic               Yin_valid;
    logic signed [15:0] Xout;
    logic               Xout_valid;
    logic               Primed;
    logic               Err;

    int n_checks;
    int n_fail;

    fir_4tap_inv #(.DW_IN(32), .DW_OUT(16), .TAPS(4)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Clr        (Clr),
        .Yin        (Yin),
        .Yin_valid  (Yin_valid),
        .Xout       (Xout),
        .Xout_valid (Xout_valid),
        .Primed     (Primed),
        .Err        (Err)
    );

    // 10 ns clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input logic signed [31:0] y, input logic v, input logic c);
        @(negedge Clk);
        Yin       = y;
        Yin_valid = v;
        Clr       = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Yin_valid = 1'b0;
        Clr       = 1'b0;
        Rst       = 1'b1;
        #2;
        Rst       = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({Xout, Xout_valid, Primed, Err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got Xout=%0d v=%0b p=%0b e=%0b, want all 0",
                     Xout, Xout_valid, Primed, Err);
        end
    endtask

    task automatic test_stream();
        logic signed [31:0] ys [6] = '{1, 3, 6, 10, 14, 18};
        logic signed [15:0] xs [6] = '{1, 2, 3, 4, 5, 6};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(ys[i], 1'b1, 1'b0);
            n_checks++;
            if (Xout !== xs[i] || Xout_valid !== 1'b1 || Primed !== (i >= 3) || Err !== 1'b0) begin
                n_fail++;
                $display("FAIL stream[%0d]: got Xout=%0d v=%0b p=%0b e=%0b, want Xout=%0d v=1 p=%0b e=0",
                         i, Xout, Xout_valid, Primed, Err, xs[i], (i >= 3));
            end
        end
        drive(0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        logic signed [31:0] ys [6] = '{1, 3, 6, 10, 14, 18};
        logic signed [15:0] xs [6] = '{1, 2, 3, 4, 5, 6};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(ys[i], 1'b1, 1'b0);
            n_checks++;
            if (Xout !== xs[i] || Xout_valid !== 1'b1 || Primed !== (i >= 3)) begin
                n_fail++;
                $display("FAIL gaps_sample[%0d]: got Xout=%0d v=%0b p=%0b, want Xout=%0d v=1 p=%0b",
                         i, Xout, Xout_valid, Primed, xs[i], (i >= 3));
            end
            for (int g = 0; g < 2; g++) begin
                drive(32'sd7777, 1'b0, 1'b0);
                n_checks++;
                if (Xout !== xs[i] || Xout_valid !== 1'b0 || Primed !== (i >= 3)) begin
                    n_fail++;
                    $display("FAIL gaps_hold[%0d.%0d]: got Xout=%0d v=%0b p=%0b, want Xout=%0d v=0 p=%0b",
                             i, g, Xout, Xout_valid, Primed, xs[i], (i >= 3));
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [15:0] exp_x;
`ifdef FIR_INV_SAT_EN
        exp_x = 16'sd32767;
`else
        exp_x = -16'sd31072;
`endif
        do_reset();
        drive(32'sd100000, 1'b1, 1'b0);
        n_checks++;
        if (Xout !== exp_x || Err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_pos: got Xout=%0d e=%0b, want Xout=%0d e=1", Xout, Err, exp_x);
        end
        // The history still reads zero at the tap, so 1 and then 2 come out.
        drive(32'sd100001, 1'b1, 1'b0);
        n_checks++;
        if (Xout !== 16'sd1 || Err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky1: got Xout=%0d e=%0b, want Xout=1 e=1", Xout, Err);
        end
        drive(32'sd100003, 1'b1, 1'b0);
        n_checks++;
        if (Xout !== 16'sd2 || Err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky2: got Xout=%0d e=%0b, want Xout=2 e=1", Xout, Err);
        end
        drive(0, 1'b0, 1'b0);
    endtask

    task automatic test_neg_clamp();
        logic signed [15:0] exp_x;
`ifdef FIR_INV_SAT_EN
        exp_x = -16'sd32768;
`else
        exp_x = 16'sd25536;
`endif
        do_reset();
        drive(-32'sd40000, 1'b1, 1'b0);
        n_checks++;
        if (Xout !== exp_x || Err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_neg: got Xout=%0d e=%0b, want Xout=%0d e=1", Xout, Err, exp_x);
        end
        drive(-32'sd40000, 1'b1, 1'b0);
        n_checks++;
        if (Xout !== 16'sd0 || Err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_neg_next: got Xout=%0d e=%0b, want Xout=0 e=1", Xout, Err);
        end
        drive(0, 1'b0, 1'b0);
    endtask

    task automatic test_clr();
        logic signed [31:0] ys [3] = '{1, 3, 6};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(ys[i], 1'b1, 1'b0);
        end
        n_checks++;
        if (Xout !== 16'sd3) begin
            n_fail++;
            $display("FAIL clr_pre: got Xout=%0d, want 3", Xout);
        end
        drive(32'sd10, 1'b1, 1'b1);
        n_checks++;
        if (Xout_valid !== 1'b0 || Primed !== 1'b0 || Err !== 1'b0 || Xout !== 16'sd0) begin
            n_fail++;
            $display("FAIL clr_priority: got Xout=%0d v=%0b p=%0b e=%0b, want 0 0 0 0",
                     Xout, Xout_valid, Primed, Err);
        end
        drive(32'sd5, 1'b1, 1'b0);
        n_checks++;
        if (Xout !== 16'sd5 || Xout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_after1: got Xout=%0d v=%0b, want Xout=5 v=1", Xout, Xout_valid);
        end
        drive(32'sd9, 1'b1, 1'b0);
        n_checks++;
        if (Xout !== 16'sd4 || Xout_valid !== 1'b1 || Primed !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_after2: got Xout=%0d v=%0b p=%0b, want Xout=4 v=1 p=0",
                     Xout, Xout_valid, Primed);
        end
        drive(0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic signed [31:0] ys [4] = '{1, 3, 6, 10};
        logic signed [15:0] xs [4] = '{1, 2, 3, 4};
        do_reset();
        // Push Err high first, so the reset has something to clear.
        drive(32'sd100000, 1'b1, 1'b0);
        drive(32'sd100001, 1'b1, 1'b0);
        // Assert reset away from any rising edge and look before the next one.
        @(negedge Clk);
        Yin_valid = 1'b0;
        Rst       = 1'b1;
        #1;
        n_checks++;
        if ({Xout, Xout_valid, Primed, Err} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset: got Xout=%0d v=%0b p=%0b e=%0b, want all 0",
                     Xout, Xout_valid, Primed, Err);
        end
        #1;
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ys[i], 1'b1, 1'b0);
            n_checks++;
            if (Xout !== xs[i] || Xout_valid !== 1'b1 || Primed !== (i == 3) || Err !== 1'b0) begin
                n_fail++;
                $display("FAIL async_after[%0d]: got Xout=%0d v=%0b p=%0b e=%0b, want Xout=%0d v=1 p=%0b e=0",
                         i, Xout, Xout_valid, Primed, Err, xs[i], (i == 3));
            end
        end
        drive(0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        Rst       = 1'b1;
        Clr       = 1'b0;
        Yin       = '0;
        Yin_valid = 1'b0;
        #12;
        Rst = 1'b0;
        test_reset();
        test_stream();
        test_gaps();
        test_overflow();
        test_neg_clamp();
        test_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Stop a runaway simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fir_4tap_inv.md
Name: fir_4tap_inv

Overview:
- Inverse (reconstruction) filter for the all-ones moving-sum FIR.
- Takes the 32-bit filtered stream y[n] and recovers the original 16-bit samples using x[n] = y[n] - y[n-1] + x[n-TAPS].
- Sits downstream of the filter in loopback and self-check paths. Also used as the equaliser stage on a link that carries the filtered stream.
- Recursive datapath with an input-valid qualifier, a priming state machine and overflow detection.

Parameters:
- DW_IN, 32, width of signed input sample Yin
- DW_OUT, 16, width of signed reconstructed sample Xout
- TAPS, 4, length of the all-ones filter being inverted (>=2); depth of the x history

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous reset, active-high
- Clr  input  1  synchronous clear of history/state, active-high
- Yin  input  DW_IN  signed filtered sample
- Yin_valid  input  1  Yin is a new sample this cycle
- Xout  output  DW_OUT  signed reconstructed sample, registered
- Xout_valid  output  1  Xout is new this cycle
- Primed  output  1  at least TAPS samples consumed since reset/clear
- Err  output  1  sticky: a result overflowed the DW_OUT range

Behaviour:
- Reset (Rst=1, async) sets the following to 0:
  - Xout, Xout_valid, Primed, Err
  - y_prev register
  - all TAPS x-history registers
  - sample counter
  - state = PRIME
- Clr (sync) has the same effect as Rst on the next rising edge. Clr has priority over Yin_valid in the same cycle; that sample is discarded and Xout_valid=0.
- Latency: 1 cycle. Yin_valid=1 at edge k gives Xout/Xout_valid=1 after edge k.
  - Xout holds its value when Yin_valid=0. Xout_valid is high for exactly one cycle per accepted sample.
- Arithmetic on an accepted sample:
  - d = Yin - y_prev, sign-extended to DW_IN+1 bits.
  - s = d + x_hist[TAPS-1], sign-extended to DW_IN+2 bits.
  - Range limits for s are -2^(DW_OUT-1) and 2^(DW_OUT-1)-1.
  - If s is in range: Xout = s.
  - Otherwise: Xout is limited per FIR_INV_SAT_EN and Err is set to 1. Err stays at 1 until Rst or Clr.
- State update on an accepted sample:
  - y_prev <= Yin.
  - The history shifts: x_hist[0] <= Xout value just produced, x_hist[i] <= x_hist[i-1].
  - The history stores the limited value, not s.
- Zero initial history is correct: the filter also starts from zero state. No special case is needed for the first TAPS samples.
- Priming FSM:
  - PRIME: counter increments per accepted sample. When the counter reaches TAPS-1 and a sample is accepted, go to RUN.
  - RUN: Primed=1, counter frozen.
  - Any state: Clr or Rst goes to PRIME.
  - Primed is registered. It rises on the same edge that produces the TAPS-th Xout_valid.
- Yin_valid=0 cycles: no state change at all; gaps of any length are transparent.
- Back-to-back Yin_valid=1 every cycle is supported; throughput is 1 sample/cycle.

Optional Feature:
- FIR_INV_SAT_EN
- Defined:
  - Out-of-range results clamp: s > max gives 2^(DW_OUT-1)-1; s < min gives -2^(DW_OUT-1).
  - Err is set on any clamp.
- Undefined:
  - Xout = s[DW_OUT-1:0] (two's-complement wrap).
  - Overflow is still detected and Err is still set.
  - The wrapped value enters the history.

Test Plan:
- Stream check. Rst, then Yin_valid=1 every cycle with Yin = 1,3,6,10,14,18. Required:
  - Xout = 1,2,3,4,5,6, each 1 cycle after its input.
  - Primed rises with the 4th output.
  - Err=0.
- Valid gaps. Same stream with Yin_valid toggled 1,0,0,1,... Required:
  - Identical Xout sequence.
  - Xout holds value and Xout_valid=0 during the gaps.
- Overflow. Rst, then Yin=100000. Required:
  - With FIR_INV_SAT_EN: Xout=32767, Err=1.
  - Without it: Xout=-31072 (100000 mod 2^16 as signed), Err=1.
  - Err stays 1 through subsequent in-range samples.
- Negative clamp, SAT_EN. Yin = -40000 → Xout=-32768, Err=1. Next Yin=-40000 → Xout=0.
- Clr priority. Mid-stream (after 1,3,6), assert Clr with Yin_valid=1 and Yin=10. Required:
  - No output.
  - Primed=0, Err=0.
  - Next inputs 5,9 give Xout=5,4.
- Async reset mid-stream. Assert Rst between clock edges. Required:
  - Xout, Xout_valid, Primed and Err go to 0 immediately, without waiting for a clock edge.
  - After release, stream 1,3,6,10 gives Xout=1,2,3,4.
